// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: pointer sizing and read-mode enum.
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Pointers carry one extra MSB as a wrap bit; count shares the same width.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage: synchronous write port, combinational read port.
module fifo_mem_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// overflow/underflow pulses and selectable standard or FWFT read mode.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          w_en,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          r_en,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int         PTR_W = ptr_width(DEPTH);
    localparam int         ADDR_W = PTR_W - 1;
    localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_LEVEL);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo_param: DEPTH must be a power of two >= 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $error("sync_fifo_param: AF_LEVEL out of range 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
            $error("sync_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
        end
        if (DATA_WIDTH < 1) begin : g_bad_width
            $error("sync_fifo_param: DATA_WIDTH must be >= 1");
        end
    endgenerate

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Flags come straight from the registered count so they move with it.
    assign full         = (r_count == DEPTH_C);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= AF_C);
    assign almost_empty = (r_count <= AE_C);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A full FIFO rejects writes even when a read is accepted in the same cycle.
    assign w_wr_acc = w_en && !full;
    assign w_rd_acc = r_en && !empty;

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_acc),
        .waddr (r_wr_ptr[ADDR_W-1:0]),
        .wdata (data_in),
        .raddr (r_rd_ptr[ADDR_W-1:0]),
        .rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_en && full;
            r_underflow <= r_en && empty;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            // Head word is presented directly; forced to zero while empty.
            assign data_out = empty ? '0 : w_rd_data;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out <= '0;
                end else if (w_rd_acc) begin
                    r_data_out <= w_rd_data;
                end
            end

            assign data_out = r_data_out;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: a standard-mode and an FWFT-mode instance.
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Standard-mode instance signals
    logic          s_w_en = 1'b0, s_r_en = 1'b0;
    logic [DW-1:0] s_din = '0, s_dout;
    logic          s_full, s_empty, s_af, s_ae, s_ov, s_uf;
    logic [3:0]    s_count;

    // FWFT-mode instance signals
    logic          f_w_en = 1'b0, f_r_en = 1'b0;
    logic [DW-1:0] f_din = '0, f_dout;
    logic          f_full, f_empty, f_af, f_ae, f_ov, f_uf;
    logic [3:0]    f_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [DW-1:0] ref_q[$];
    logic [DW-1:0] exp_d;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .w_en(s_w_en), .data_in(s_din), .r_en(s_r_en),
        .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ov), .underflow(s_uf)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(f_w_en), .data_in(f_din), .r_en(f_r_en),
        .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ov), .underflow(f_uf)
    );

    // One rising edge, then settle; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc=%0d std: w=%0b r=%0b din=%h dout=%h cnt=%0d | fwft: w=%0b r=%0b dout=%h cnt=%0d",
                 cyc, s_w_en, s_r_en, s_din, s_dout, s_count, f_w_en, f_r_en, f_dout, f_count);
    endtask

    task automatic test_reset_fill();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++; if (s_dout !== 8'h00) begin failures++; $display("FAIL rst_dout got=%h exp=00", s_dout); end
        checks++; if (s_count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", s_count); end
        checks++; if ({s_empty, s_full, s_ae, s_af} !== 4'b1010) begin
            failures++; $display("FAIL rst_flags got=%b exp=1010 (empty,full,ae,af)", {s_empty, s_full, s_ae, s_af});
        end
        checks++; if ({s_ov, s_uf} !== 2'b00) begin failures++; $display("FAIL rst_pulses got=%b exp=00", {s_ov, s_uf}); end
        for (int i = 1; i <= 8; i++) begin
            s_w_en = 1'b1; s_din = 8'(i);
            tick();
            checks++; if (s_count !== 4'(i)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", s_count, i); end
            checks++; if ({s_ae, s_af, s_full} !== {(i <= 2), (i >= 6), (i == 8)}) begin
                failures++; $display("FAIL fill_flags i=%0d got=%b exp=%b", i, {s_ae, s_af, s_full},
                                     {(i <= 2), (i >= 6), (i == 8)});
            end
        end
        s_w_en = 1'b0;
    endtask

    task automatic test_overflow_drain();
        s_w_en = 1'b1; s_din = 8'hFF;
        tick();
        s_w_en = 1'b0;
        checks++; if (s_ov !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", s_ov); end
        checks++; if (s_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", s_count); end
        tick();
        checks++; if (s_ov !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", s_ov); end
        for (int i = 1; i <= 8; i++) begin
            s_r_en = 1'b1;
            tick();
            checks++; if (s_dout !== 8'(i)) begin failures++; $display("FAIL drain_data got=%h exp=%h", s_dout, 8'(i)); end
            checks++; if (s_count !== 4'(8 - i)) begin failures++; $display("FAIL drain_count got=%0d exp=%0d", s_count, 8 - i); end
        end
        s_r_en = 1'b0;
        checks++; if (s_empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", s_empty); end
    endtask

    task automatic test_underflow_simul();
        s_r_en = 1'b1;
        tick();
        s_r_en = 1'b0;
        checks++; if (s_uf !== 1'b1) begin failures++; $display("FAIL udf_pulse got=%b exp=1", s_uf); end
        checks++; if (s_dout !== 8'h08) begin failures++; $display("FAIL udf_hold got=%h exp=08", s_dout); end
        checks++; if (s_count !== 4'd0) begin failures++; $display("FAIL udf_count got=%0d exp=0", s_count); end
        tick();
        checks++; if (s_uf !== 1'b0) begin failures++; $display("FAIL udf_clear got=%b exp=0", s_uf); end
        ref_q.delete();
        for (int i = 0; i < 4; i++) begin
            s_w_en = 1'b1; s_din = 8'h10 + 8'(i); ref_q.push_back(s_din);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            s_w_en = 1'b1; s_r_en = 1'b1; s_din = 8'h20 + 8'(k);
            exp_d = ref_q.pop_front(); ref_q.push_back(s_din);
            tick();
            checks++; if (s_dout !== exp_d) begin failures++; $display("FAIL simul_data got=%h exp=%h", s_dout, exp_d); end
            checks++; if (s_count !== 4'd4) begin failures++; $display("FAIL simul_count got=%0d exp=4", s_count); end
        end
        s_r_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_w_en = 1'b1; s_din = 8'h40 + 8'(i); ref_q.push_back(s_din);
            tick();
        end
        checks++; if (s_full !== 1'b1) begin failures++; $display("FAIL refill_full got=%b exp=1", s_full); end
        // Full: the write is rejected even though a read is accepted.
        s_w_en = 1'b1; s_r_en = 1'b1; s_din = 8'hEE;
        exp_d = ref_q.pop_front();
        tick();
        checks++; if (s_ov !== 1'b1) begin failures++; $display("FAIL full_rw_ovf got=%b exp=1", s_ov); end
        checks++; if (s_count !== 4'd7) begin failures++; $display("FAIL full_rw_count got=%0d exp=7", s_count); end
        checks++; if (s_dout !== exp_d) begin failures++; $display("FAIL full_rw_data got=%h exp=%h", s_dout, exp_d); end
        s_w_en = 1'b0;
        while (ref_q.size() > 0) begin
            exp_d = ref_q.pop_front();
            tick();
            checks++; if (s_dout !== exp_d) begin failures++; $display("FAIL rest_data got=%h exp=%h", s_dout, exp_d); end
        end
        s_r_en = 1'b0;
        tick();
        // Empty: the read is rejected, the write still lands.
        s_w_en = 1'b1; s_r_en = 1'b1; s_din = 8'h77;
        tick();
        s_w_en = 1'b0; s_r_en = 1'b0;
        checks++; if (s_uf !== 1'b1) begin failures++; $display("FAIL empty_rw_udf got=%b exp=1", s_uf); end
        checks++; if (s_count !== 4'd1) begin failures++; $display("FAIL empty_rw_count got=%0d exp=1", s_count); end
        s_r_en = 1'b1;
        tick();
        s_r_en = 1'b0;
        checks++; if (s_dout !== 8'h77) begin failures++; $display("FAIL empty_rw_data got=%h exp=77", s_dout); end
    endtask

    task automatic test_wrap();
        ref_q.delete();
        for (int r = 0; r < 4; r++) begin
            int n;
            n = (r == 0) ? 5 : 8;
            for (int i = 0; i < n; i++) begin
                s_w_en = 1'b1; s_din = 8'($urandom_range(0, 255)); ref_q.push_back(s_din);
                tick();
            end
            s_w_en = 1'b0;
            for (int i = 0; i < n; i++) begin
                s_r_en = 1'b1; exp_d = ref_q.pop_front();
                tick();
                checks++; if (s_dout !== exp_d) begin failures++; $display("FAIL wrap_data round=%0d got=%h exp=%h", r, s_dout, exp_d); end
            end
            s_r_en = 1'b0;
        end
        checks++; if (s_empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", s_empty); end
    endtask

    task automatic test_fwft();
        f_w_en = 1'b1; f_din = 8'hA5;
        tick();
        f_w_en = 1'b0;
        checks++; if (f_dout !== 8'hA5) begin failures++; $display("FAIL fwft_first got=%h exp=a5", f_dout); end
        checks++; if (f_empty !== 1'b0) begin failures++; $display("FAIL fwft_empty got=%b exp=0", f_empty); end
        f_w_en = 1'b1; f_din = 8'h5A;
        tick();
        f_w_en = 1'b0;
        checks++; if (f_dout !== 8'hA5) begin failures++; $display("FAIL fwft_hold got=%h exp=a5", f_dout); end
        f_r_en = 1'b1;
        tick();
        f_r_en = 1'b0;
        checks++; if (f_dout !== 8'h5A) begin failures++; $display("FAIL fwft_next got=%h exp=5a", f_dout); end
        checks++; if (f_count !== 4'd1) begin failures++; $display("FAIL fwft_count got=%0d exp=1", f_count); end
        f_r_en = 1'b1;
        tick();
        f_r_en = 1'b0;
        checks++; if (f_empty !== 1'b1) begin failures++; $display("FAIL fwft_drain got=%b exp=1", f_empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            s_w_en = 1'b1; s_din = 8'hC0 + 8'(i);
            tick();
        end
        s_w_en = 1'b0;
        checks++; if (s_count !== 4'd5) begin failures++; $display("FAIL mid_pre_count got=%0d exp=5", s_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (s_count !== 4'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", s_count); end
        checks++; if (s_empty !== 1'b1) begin failures++; $display("FAIL mid_rst_empty got=%b exp=1", s_empty); end
        s_w_en = 1'b1; s_din = 8'h3C;
        tick();
        s_w_en = 1'b0; s_r_en = 1'b1;
        tick();
        s_r_en = 1'b0;
        checks++; if (s_dout !== 8'h3C) begin failures++; $display("FAIL mid_post_data got=%h exp=3c", s_dout); end
        checks++; if (s_empty !== 1'b1) begin failures++; $display("FAIL mid_post_empty got=%b exp=1", s_empty); end
    endtask

    initial begin
        test_reset_fill();
        test_overflow_drain();
        test_underflow_simul();
        test_wrap();
        test_fwft();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
